// File: rtl/reanimator_unit_if.sv
// Bus between the mood FSM and the reanimator: stimulus level and mood
// state flow in, the one-cycle reanimation pulse flows back out.
// All three signals are plain levels sampled on the rising clock edge;
// there is no valid/ready handshake, every cycle carries a sample.
interface reanimator_unit_if;
  logic       stimulus;
  logic [1:0] state;
  logic       reanimated;

  // Driver side: the mood FSM / touch sensor environment.
  modport master (
    output stimulus,
    output state,
    input  reanimated
  );

  // Receiver side: the reanimator block itself.
  modport slave (
    input  stimulus,
    input  state,
    output reanimated
  );
endinterface

// File: rtl/reanimator_unit.sv
// Wake-up detector for the dormant mood state. While the mood FSM is
// dormant, rising edges of the stimulus level are counted. When the
// count reaches the limit, a registered one-cycle pulse is raised and the
// count restarts. Outside the dormant state the counter is held at zero
// and edges are dropped. rst_n is an active-high synchronous reset; the
// name is kept for compatibility with the surrounding codebase.
module reanimator_unit #(
  parameter int unsigned COUNTER_LIMIT = 8,
  parameter int unsigned COUNTER_WIDTH = 4,
  parameter logic [1:0]  DEAD_STATE    = 2'b11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  reanimator_unit_if.slave         bus,
  // Debug view of the edge counter for checker binding.
  output logic [COUNTER_WIDTH-1:0] count_o
);

  // A limit of 0 is treated as 1 so a single edge always suffices.
  localparam int unsigned LIMIT_EFF = (COUNTER_LIMIT == 0) ? 1 : COUNTER_LIMIT;
  // Comparison is done one bit wider than the counter, so count+1 never wraps.
  localparam logic [COUNTER_WIDTH:0] LIMIT_EXT = LIMIT_EFF[COUNTER_WIDTH:0];
  localparam logic [COUNTER_WIDTH:0] ONE_EXT   = {{COUNTER_WIDTH{1'b0}}, 1'b1};

  logic                     stim_q;
  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     reanimated_q, reanimated_d;

  logic                     edge_seen;
  logic                     dormant;
  logic [COUNTER_WIDTH:0]   count_inc;

  assign edge_seen = bus.stimulus & ~stim_q;
  assign dormant   = (bus.state == DEAD_STATE);
  assign count_inc = {1'b0, count_q} + ONE_EXT;

  // Next count and pulse decision from mood state and the detected edge.
  always_comb begin
    count_d      = count_q;
    reanimated_d = 1'b0;
    if (!dormant) begin
      count_d = '0;
    end else if (edge_seen) begin
      if (count_inc >= LIMIT_EXT) begin
        count_d      = '0;
        reanimated_d = 1'b1;
      end else begin
        count_d = count_inc[COUNTER_WIDTH-1:0];
      end
    end
  end

  // State registers; the previous stimulus sample updates regardless of mood.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stim_q       <= 1'b0;
      count_q      <= '0;
      reanimated_q <= 1'b0;
    end else begin
      stim_q       <= bus.stimulus;
      count_q      <= count_d;
      reanimated_q <= reanimated_d;
    end
  end

  assign bus.reanimated = reanimated_q;
  assign count_o        = count_q;

endmodule

// File: tb/tb_reanimator_unit.sv
// Self-checking bench for reanimator_unit with COUNTER_LIMIT=4.
// Directed scenarios followed by a randomized phase, all compared against
// a behavioural model that tracks edges and the count as plain integers.
module tb_reanimator_unit;
  localparam int LIMIT = 4;
  localparam int CW    = 4;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] count_dbg;

  reanimator_unit_if bus ();

  reanimator_unit #(
    .COUNTER_LIMIT (LIMIT),
    .COUNTER_WIDTH (CW),
    .DEAD_STATE    (2'b11)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .count_o (count_dbg)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total;
  int checks_passed;
  int pulse_cnt;

  // Behavioural model state
  int model_count;
  bit model_prev;
  logic [0:0]    exp_q[$];
  logic [CW-1:0] exp_cnt_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Predict the result of one clock edge from the stimulus rules.
  task automatic model_edge(input bit stim, input logic [1:0] st, input bit rst);
    bit rising;
    bit pulse;
    pulse = 1'b0;
    if (rst) begin
      model_count = 0;
      model_prev  = 1'b0;
    end else begin
      rising     = stim && !model_prev;
      model_prev = stim;
      if (st != 2'b11) model_count = 0;
      else if (rising) begin
        if (model_count + 1 >= LIMIT) begin
          pulse       = 1'b1;
          model_count = 0;
        end else model_count = model_count + 1;
      end
    end
    exp_q.push_back(pulse);
    exp_cnt_q.push_back(model_count[CW-1:0]);
  endtask

  // Driver: apply inputs for one cycle, then compare after the edge.
  task automatic step(input bit stim, input logic [1:0] st, input bit rst, input string tag);
    logic [0:0]    e;
    logic [CW-1:0] ec;
    bus.stimulus = stim;
    bus.state    = st;
    rst_n        = rst;
    model_edge(stim, st, rst);
    @(posedge clk);
    #1;
    e  = exp_q.pop_front();
    ec = exp_cnt_q.pop_front();
    check({tag, "_pulse"}, {31'd0, bus.reanimated}, {31'd0, e});
    check({tag, "_count"}, {28'd0, count_dbg}, {28'd0, ec});
    if (bus.reanimated === 1'b1) pulse_cnt++;
  endtask

  task automatic pulses(input int n, input logic [1:0] st, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, st, 1'b0, tag);
      step(1'b0, st, 1'b0, tag);
    end
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    model_count   = 0;
    model_prev    = 1'b0;
    bus.stimulus  = 1'b0;
    bus.state     = 2'b00;
    rst_n         = 1'b1;

    // 1. Reset with stimulus toggling
    step(1'b1, 2'b11, 1'b1, "rst");
    step(1'b0, 2'b11, 1'b1, "rst");
    check("rst_count_zero", {28'd0, count_dbg}, 32'd0);
    step(1'b0, 2'b00, 1'b0, "idle");

    // 2. Basic reanimation: no pulse after edges 1..3, pulse after edge 4
    pulse_cnt = 0;
    pulses(3, 2'b11, "basic");
    check("basic_no_early", pulse_cnt, 0);
    step(1'b1, 2'b11, 1'b0, "basic4");
    check("basic_latency", {31'd0, bus.reanimated}, 32'd1);
    step(1'b0, 2'b11, 1'b0, "basic4");
    check("basic_one_cycle", {31'd0, bus.reanimated}, 32'd0);
    check("basic_pulses", pulse_cnt, 1);

    // 3. Held level counts once
    pulse_cnt = 0;
    for (int i = 0; i < 10; i++) step(1'b1, 2'b11, 1'b0, "held");
    step(1'b0, 2'b11, 1'b0, "held");
    pulses(2, 2'b11, "held");
    check("held_no_early", pulse_cnt, 0);
    pulses(1, 2'b11, "held");
    check("held_pulses", pulse_cnt, 1);

    // 4. Edges outside dormant state are discarded
    pulse_cnt = 0;
    pulses(6, 2'b00, "notdead");
    pulses(3, 2'b11, "notdead");
    check("notdead_none", pulse_cnt, 0);
    pulses(1, 2'b11, "notdead");
    check("notdead_fire", pulse_cnt, 1);

    // 5. Abort mid-count
    pulse_cnt = 0;
    pulses(3, 2'b11, "abort");
    step(1'b0, 2'b01, 1'b0, "abort");
    check("abort_cleared", {28'd0, count_dbg}, 32'd0);
    pulses(3, 2'b11, "abort");
    check("abort_none", pulse_cnt, 0);
    pulses(1, 2'b11, "abort");
    check("abort_fire", pulse_cnt, 1);

    // 6. Reset mid-count, then two full rounds
    pulse_cnt = 0;
    pulses(3, 2'b11, "rstmid");
    step(1'b0, 2'b11, 1'b1, "rstmid");
    pulses(4, 2'b11, "rstmid");
    check("rstmid_first", pulse_cnt, 1);
    pulses(4, 2'b11, "rstmid");
    check("rstmid_second", pulse_cnt, 2);

    // Stimulus held high through reset release counts as an edge
    step(1'b1, 2'b11, 1'b1, "relhi");
    step(1'b1, 2'b11, 1'b0, "relhi");
    check("relhi_count", {28'd0, count_dbg}, 32'd1);

    // Randomized phase
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] st;
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      step(1'($urandom_range(0, 1)), st, ($urandom_range(0, 99) == 0), "rand");
    end

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule

// File: doc/reanimator_unit.md
# reanimator_unit

Stimulus-driven wake-up detector for the mimosa mood FSM. While the mood FSM reports the dormant ("dead") state, the block counts rising edges on `stimulus`. When the count reaches `COUNTER_LIMIT`, it emits a one-cycle `reanimated` pulse, which tells the mood FSM to leave the dormant state. In any other state the block stays idle and its counter is held at zero.

## Interface
Parameters:
- `COUNTER_LIMIT`, default 8: number of stimulus rising edges needed for reanimation. Legal range is 1..2^`COUNTER_WIDTH`-1. A value of 0 behaves as 1.
- `COUNTER_WIDTH`, default 4: width of the internal edge counter.
- `DEAD_STATE`, default 2'b11: encoding of `state` that means dormant.

Ports:
- `clk`, input, 1 bit: single clock. All logic updates on its rising edge.
- `rst_n`, input, 1 bit: one clock; reset is synchronous and active-high. The port keeps the codebase name `rst_n`, but it is asserted high and sampled only on `clk` rising edges.
- `stimulus`, input, 1 bit: touch/stimulus level. Synchronous to `clk`.
- `state`, input, 2 bits: current mood-FSM state.
- `reanimated`, output, 1 bit: registered, one-cycle pulse when the edge limit is reached.

## Operation
- Internal registers:
  - `stim_q`: previous sample of `stimulus`.
  - `count`, `COUNTER_WIDTH` bits: rising-edge counter.
  - `reanimated`: registered output.
- Edge detect: `edge = stimulus & ~stim_q`. `stim_q <= stimulus` every non-reset cycle, independent of `state`.
- `state != DEAD_STATE` (idle): `count <= 0`, `reanimated <= 0`. Edges are ignored and not remembered.
- `state == DEAD_STATE`, no edge: `count` holds, `reanimated <= 0`.
- `state == DEAD_STATE`, edge, and `count + 1 < COUNTER_LIMIT`: `count <= count + 1`, `reanimated <= 0`.
- `state == DEAD_STATE`, edge, and `count + 1 >= COUNTER_LIMIT`:
  - `reanimated <= 1`.
  - `count <= 0`.
- Counting after a pulse: if `state` stays at `DEAD_STATE` after the pulse, counting restarts from 0 and a further `COUNTER_LIMIT` edges produce another pulse.
- Arithmetic: `count + 1` is compared at `COUNTER_WIDTH+1` bits, so no wrap-around is possible. The counter never exceeds `COUNTER_LIMIT-1`.
- Level vs. edge: a `stimulus` held high counts exactly once. It must return low for at least one cycle before the next edge counts.

## Timing
- Reset (`rst_n == 1` at a clock edge): `count = 0`, `stim_q = 0`, `reanimated = 0` after that edge. Reset overrides all other behaviour, including mid-count and during a pulse.
- Reset release edge case: because `stim_q` resets to 0, a `stimulus` held high through reset release counts as an edge on the first non-reset cycle, provided `state == DEAD_STATE`.
- Latency: `reanimated` goes high at the same clock edge that samples the `COUNTER_LIMIT`-th qualifying edge, i.e. it is visible in the cycle after the input edge was presented. It stays high for exactly 1 cycle.
- Leaving dormant mid-count: `state` changing away from `DEAD_STATE` clears `count` at that clock edge. Re-entering the dormant state starts from 0.
- Simultaneous events: an edge that arrives in a cycle where `state != DEAD_STATE` is discarded. It is not counted later, even if `state` becomes `DEAD_STATE` while `stimulus` is still high.
- Back-to-back pulses: the fastest rate is one pulse per 2×`COUNTER_LIMIT` cycles, since a toggling `stimulus` yields one edge per 2 cycles.
- No combinational path from inputs to `reanimated`.

## Test plan
All scenarios use `COUNTER_LIMIT=4`, `COUNTER_WIDTH=4`, `DEAD_STATE=2'b11`.
1. Reset: assert `rst_n=1` for 2 cycles with `stimulus` toggling → `reanimated=0` and `count=0` throughout.
2. Basic reanimation: `state=3`, apply 4 stimulus pulses (1 cycle high, 1 cycle low) → `reanimated=1` for exactly one cycle, in the cycle after the 4th rising edge. It is 0 after the 1st to 3rd edges.
3. Held level: `state=3`, `stimulus` held high for 10 cycles, then 3 further pulses → the held level counts once, so the pulse fires after the 3rd further pulse (4 total).
4. Not dormant: `state=0`, 6 pulses, then `state=3`, 3 pulses → no pulse, because the count is 3 (the earlier edges were discarded). A 4th pulse then fires `reanimated`.
5. Abort mid-count: `state=3`, 3 pulses, `state=1` for 1 cycle, back to `state=3`, 3 pulses → no pulse. A 4th pulse fires it.
6. Reset mid-count and repeat: `state=3`, 3 pulses, then `rst_n=1` for 1 cycle, then 4 pulses → exactly one pulse. A further 4 pulses with `state` still 3 → a second pulse.
